control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  8-phase instruction sequencer for the RISC CPU. Steps through fetch/execute phases
//  and decodes the 3-bit opcode and ALU zero flag into the datapath control strobes:
//  memory read/write, IR load, PC increment/load, accumulator load and data_e.
//  data_e directly drives the enable of driver_bus, the tri-state bus driver.
// PARAMETERS
//  PHASE_W    3    phase counter width; fixed at 3 (8 phases)
//  OPCODE_W   3    opcode field width from the instruction register
// PORTS
//  clk     in   1          single system clock; all state updates on rising edge
//  rst     in   1          synchronous, active-high reset
//  opcode  in   OPCODE_W   IR opcode: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
//  zero    in   1          accumulator-is-zero flag from ALU
//  sel     out  1          address mux select: 1=PC, 0=IR operand
//  rd      out  1          memory read strobe
//  wr      out  1          memory write strobe
//  ld_ir   out  1          load instruction register
//  inc_pc  out  1          increment program counter
//  ld_pc   out  1          load PC from operand
//  ld_ac   out  1          load accumulator from ALU
//  data_e  out  1          enable driver_bus onto shared `DATA_WIDTH bus
//  halt    out  1          CPU halted indication
//  phase   out  PHASE_W    current phase (debug/bench visibility)
// BEHAVIOUR
//  - State: phase[2:0] register and sticky halted flag. Rising edge with rst=1: phase=0,
//    halted=0. While rst=1, every control output is forced 0 (data_e=0, bus stays high-Z).
//  - Otherwise phase increments by 1 each clock, wrapping 7->0 (one instruction per 8 clocks).
//  - Outputs are combinational decodes of current phase, opcode and zero (zero latency).
//    ALUOP = opcode in {ADD,AND,XOR,LDA}.
//    0 INST_ADDR : sel=1
//    1 INST_FETCH: sel=1 rd=1
//    2 INST_LOAD : sel=1 rd=1 ld_ir=1
//    3 IDLE      : sel=1 rd=1 ld_ir=1
//    4 OP_ADDR   : inc_pc=1; halt=(opcode==HLT)
//    5 OP_FETCH  : rd=ALUOP
//    6 ALU_OP    : rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO)
//    7 STORE     : rd=ALUOP; inc_pc=ld_pc=(opcode==JMP); ld_ac=ALUOP; wr=data_e=(opcode==STO)
//  - Unlisted outputs are 0 in each phase. wr is never asserted without data_e.
//  - Halt: in phase 4 with opcode==HLT, halted is set at that clock edge. Thereafter phase
//    freezes at 4. Outputs are halt=1 with all others 0 (no further inc_pc), independent of
//    opcode/zero changes. Only rst clears halted.
//  - Reset mid-instruction: the next cycle is phase 0 regardless of the current phase. No
//    partial wr/data_e is emitted after rst is sampled.
//  - opcode/zero are don't-care in phases 0-3.
// CONFIGURATION
//  CTRL_SINGLE_STEP_EN defined: adds input port step (1 bit, after zero). Phase 0 advances
//    to 1 only on an edge with step=1; otherwise it holds at 0 with sel=1 only. Phases 1-7
//    advance unconditionally. step held at 1 gives free-running behaviour. rst overrides step.
//    Halt overrides step.
//  Not defined: no step port; phase counter free-runs as described above.
// TESTING
//  1 Reset: rst=1 for 2 clk -> all outputs 0, phase=0. Release -> phase 0,1,..,7,0 on
//    successive clocks; sel=1 in phases 0-3.
//  2 opcode=STO: phase 6 -> data_e=1 wr=0; phase 7 -> data_e=1 wr=1. data_e=0 in all other
//    phases.
//  3 opcode=SKZ: zero=1 -> inc_pc=1 in phase 6. zero=0 -> inc_pc=0 in phase 6. inc_pc=1 in
//    phase 4 in both cases.
//  4 opcode=JMP -> ld_pc=1 in phases 6,7 and inc_pc=1 in phase 7. opcode=ADD -> rd=1 in
//    phases 5-7, ld_ac=1 in phase 7, ld_pc=0.
//  5 opcode=HLT -> phase 4 halt=1 inc_pc=1. Next 10 clk: phase stays 4, halt=1, other
//    outputs 0. rst=1 -> phase 0, halt=0.
//  6 CTRL_SINGLE_STEP_EN, step=0 -> phase stays 0 for 5 clk. One-cycle step=1 pulse -> exactly
//    one instruction (phases 1..7), then holds at phase 0. rst asserted in phase 6 -> phase 0
//    next clk, data_e=0.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control-strobe bundle between the instruction sequencer and the datapath.
//   slave  : sequencer side (takes opcode/zero[/step], drives strobes + phase)
//   master : datapath side (drives opcode/zero[/step], takes strobes + phase)
// Strobes: sel rd wr ld_ir inc_pc ld_pc ld_ac data_e halt; phase is debug visibility.
// CTRL_SINGLE_STEP_EN adds the step input.
interface control_sequencer_if #(
  parameter int OPCODE_W = 3,
  parameter int PHASE_W  = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
`ifdef CTRL_SINGLE_STEP_EN
  logic                step;
`endif
  logic                sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
  logic [PHASE_W-1:0]  phase;

`ifdef CTRL_SINGLE_STEP_EN
  modport slave  (input  opcode, zero, step,
                  output sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt, phase);
  modport master (output opcode, zero, step,
                  input  sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt, phase);
`else
  modport slave  (input  opcode, zero,
                  output sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt, phase);
  modport master (output opcode, zero,
                  input  sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt, phase);
`endif
endinterface

// File: rtl/control_sequencer.sv
// 8-phase instruction sequencer for the RISC CPU. Walks fetch/execute phases and
// decodes opcode + ALU zero flag into datapath control strobes (zero-latency decode).
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset; forces all strobes low while asserted
//   bus  : control_sequencer_if.slave (opcode, zero[, step] in; strobes, phase out)
// Option: define CTRL_SINGLE_STEP_EN to gate the phase 0 -> 1 advance with bus.step.
module control_sequencer #(
  parameter int OPCODE_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  control_sequencer_if.slave    bus
);
  localparam int PHASE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SKZ = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_STO = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(7);

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   adv0;

`ifdef CTRL_SINGLE_STEP_EN
  assign adv0 = bus.step;
`else
  assign adv0 = 1'b1;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // next state: halting freezes the counter at OP_ADDR
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (phase_q == OP_ADDR && bus.opcode == OP_HLT)
        halted_d = 1'b1;
      else if (phase_q != INST_ADDR || adv0)
        phase_d = phase_e'(phase_q + 3'd1);
    end
  end

  // output decode
  logic aluop, is_sto, is_jmp;
  assign aluop  = bus.opcode inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
  assign is_sto = (bus.opcode == OP_STO);
  assign is_jmp = (bus.opcode == OP_JMP);

  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.wr     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;
    if (rst) begin
      // keep the bus driver off while in reset
    end else if (halted_q) begin
      bus.halt = 1'b1;
    end else begin
      unique case (phase_q)
        INST_ADDR:  bus.sel = 1'b1;
        INST_FETCH: begin bus.sel = 1'b1; bus.rd = 1'b1; end
        INST_LOAD,
        IDLE:       begin bus.sel = 1'b1; bus.rd = 1'b1; bus.ld_ir = 1'b1; end
        OP_ADDR:    begin bus.inc_pc = 1'b1; bus.halt = (bus.opcode == OP_HLT); end
        OP_FETCH:   bus.rd = aluop;
        ALU_OP: begin
          bus.rd     = aluop;
          bus.inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
          bus.ld_pc  = is_jmp;
          bus.data_e = is_sto;
        end
        STORE: begin
          bus.rd     = aluop;
          bus.inc_pc = is_jmp;
          bus.ld_pc  = is_jmp;
          bus.ld_ac  = aluop;
          bus.wr     = is_sto;
          bus.data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

  assign bus.phase = phase_q;
endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  control_sequencer_if #(.OPCODE_W(3), .PHASE_W(3)) bus ();
  control_sequencer #(.OPCODE_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // {sel,rd,wr,ld_ir,inc_pc,ld_pc,ld_ac,data_e,halt}
  logic [8:0] out;
  assign out = {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.inc_pc,
                bus.ld_pc, bus.ld_ac, bus.data_e, bus.halt};

  // reference model state
  int mph;
  bit mhalt;

  function automatic logic [8:0] ref_out(int ph, int opc, bit z, bit halted, bit r);
    bit alu, sel, rd, wr, ir, inc, ldpc, ldac, de, hl;
    if (r) return 9'd0;
    if (halted) return 9'b000000001;
    alu  = (opc >= 2) && (opc <= 5);
    sel  = ph < 4;
    rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    ir   = (ph == 2) || (ph == 3);
    inc  = (ph == 4) || (ph == 6 && opc == 1 && z) || (ph == 7 && opc == 7);
    ldpc = (ph >= 6) && (opc == 7);
    ldac = (ph == 7) && alu;
    de   = (ph >= 6) && (opc == 6);
    wr   = (ph == 7) && (opc == 6);
    hl   = (ph == 4) && (opc == 0);
    return {sel, rd, wr, ir, inc, ldpc, ldac, de, hl};
  endfunction

  task automatic ref_step(int opc, bit r, bit stp);
    if (r) begin mph = 0; mhalt = 0; end
    else if (mhalt) ;
    else if (mph == 4 && opc == 0) mhalt = 1;
    else if (mph == 0 && !stp) ;
    else mph = (mph + 1) % 8;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_step(bit s);
`ifdef CTRL_SINGLE_STEP_EN
    bus.step = s;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(); cyc();
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_phase", 32'(bus.phase), 32'd0);
    rst = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [2:0] opc;
    logic       z;
    int         ph;
    logic [8:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    rst = 1'b1;
    bus.opcode = 3'd2;
    bus.zero = 1'b0;
    set_step(1'b1);

    vt = '{
      '{3'd2, 1'b0, 0, 9'b100000000}, '{3'd2, 1'b0, 1, 9'b110000000},
      '{3'd2, 1'b0, 2, 9'b110100000}, '{3'd2, 1'b0, 3, 9'b110100000},
      '{3'd2, 1'b0, 4, 9'b000010000}, '{3'd2, 1'b0, 5, 9'b010000000},
      '{3'd2, 1'b0, 6, 9'b010000000}, '{3'd2, 1'b0, 7, 9'b010000100},
      '{3'd6, 1'b0, 5, 9'b000000000}, '{3'd6, 1'b0, 6, 9'b000000010},
      '{3'd6, 1'b0, 7, 9'b001000010}, '{3'd1, 1'b1, 6, 9'b000010000},
      '{3'd1, 1'b0, 6, 9'b000000000}, '{3'd1, 1'b0, 4, 9'b000010000},
      '{3'd7, 1'b0, 6, 9'b000001000}, '{3'd7, 1'b0, 7, 9'b000011000},
      '{3'd0, 1'b0, 4, 9'b000010001}, '{3'd5, 1'b1, 7, 9'b010000100},
      '{3'd3, 1'b0, 5, 9'b010000000}
    };

    // table-driven decode vectors
    foreach (vt[i]) begin
      bus.opcode = vt[i].opc;
      bus.zero   = vt[i].z;
      do_reset();
      for (int k = 0; k < vt[i].ph; k++) cyc();
      chk($sformatf("vec%0d_phase", i), 32'(bus.phase), 32'(vt[i].ph));
      chk($sformatf("vec%0d_out", i), 32'(out), 32'(vt[i].exp));
    end

    // free-running sequence after reset
    bus.opcode = 3'd4;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      chk("seq_phase", 32'(bus.phase), 32'(k % 8));
      chk("seq_sel", 32'(bus.sel), 32'(k % 8 < 4));
      cyc();
    end

    // halt: freeze at phase 4, strobes dead except halt, cleared only by rst
    bus.opcode = 3'd0;
    do_reset();
    for (int k = 0; k < 4; k++) cyc();
    chk("hlt_p4_out", 32'(out), 32'(9'b000010001));
    for (int k = 0; k < 10; k++) begin
      cyc();
      bus.opcode = 3'($urandom);
      bus.zero   = 1'($urandom);
      set_step(1'($urandom));
      #1;
      chk("hlt_phase", 32'(bus.phase), 32'd4);
      chk("hlt_out", 32'(out), 32'(9'b000000001));
    end
    set_step(1'b1);
    rst = 1'b1;
    cyc();
    chk("hlt_rst_phase", 32'(bus.phase), 32'd0);
    chk("hlt_rst_halt", 32'(bus.halt), 32'd0);
    rst = 1'b0;
    #1;
    chk("hlt_rel_halt", 32'(bus.halt), 32'd0);

    // reset mid-instruction during a store
    bus.opcode = 3'd6;
    do_reset();
    for (int k = 0; k < 6; k++) cyc();
    chk("sto_p6_de", 32'(bus.data_e), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out", 32'(out), 32'd0);
    cyc();
    chk("midrst_phase", 32'(bus.phase), 32'd0);
    chk("midrst_out2", 32'(out), 32'd0);
    rst = 1'b0;

`ifdef CTRL_SINGLE_STEP_EN
    // single step: hold at 0, one pulse -> one instruction
    bus.opcode = 3'd2;
    set_step(1'b0);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("step_hold_phase", 32'(bus.phase), 32'd0);
      chk("step_hold_out", 32'(out), 32'(9'b100000000));
    end
    set_step(1'b1);
    cyc();
    set_step(1'b0);
    for (int k = 1; k < 8; k++) begin
      #1;
      chk("step_run_phase", 32'(bus.phase), 32'(k));
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      chk("step_end_phase", 32'(bus.phase), 32'd0);
      cyc();
    end
    // rst in phase 6 with step low
    bus.opcode = 3'd6;
    set_step(1'b1);
    cyc();
    set_step(1'b0);
    for (int k = 1; k < 6; k++) cyc();
    chk("step_p6", 32'(bus.phase), 32'd6);
    rst = 1'b1;
    #1;
    chk("step_rst_de", 32'(bus.data_e), 32'd0);
    cyc();
    chk("step_rst_phase", 32'(bus.phase), 32'd0);
    rst = 1'b0;
    set_step(1'b1);
`endif

    // randomized run against reference model
    do_reset();
    mph = 0;
    mhalt = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] opc;
      bit z, r, s;
      opc = 3'($urandom);
      z   = 1'($urandom);
      r   = ($urandom_range(0, 24) == 0);
      s   = ($urandom_range(0, 3) != 0);
      bus.opcode = opc;
      bus.zero   = z;
      rst        = r;
      set_step(s);
`ifndef CTRL_SINGLE_STEP_EN
      s = 1'b1;
`endif
      #1;
      chk("rnd_phase", 32'(bus.phase), 32'(mph));
      chk("rnd_out", 32'(out), 32'(ref_out(mph, int'(opc), z, mhalt, r)));
      ref_step(int'(opc), r, s);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
